dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 4096-word data memory between the processor's MM stage and a host port used for program load, debug dump and DMA. The MM stage has priority each cycle. The host runs multi-beat bursts with an auto-incrementing word address in cycles the CPU leaves free. An optional starvation guard forces a host beat after a bounded wait, stalling the pipeline for exactly one cycle.

## Interface
- `ADDR_W`, 12 — word-address width; the memory holds 2^ADDR_W words.
- `LEN_W`, 8 — width of the burst length field.
- `STARVE_MAX`, 8 — number of consecutive denied host cycles before a beat is forced; legal range ≥1.
- `clk` in 1 — the single clock.
- `rst` in 1 — synchronous, active-high reset.
- `cpu_req` in 1 — MM stage memory access this cycle.
- `cpu_we` in 1 — CPU write.
- `cpu_addr` in ADDR_W — CPU word address.
- `cpu_wdata` in 32 — CPU store data.
- `cpu_rdata` out 32 — CPU load data, same cycle as the request.
- `cpu_stall` out 1 — CPU denied this cycle; the pipeline holds and the request is retried.
- `host_req` in 1 — start a burst; sampled only in IDLE.
- `host_we` in 1 — burst direction (1 = write).
- `host_addr` in ADDR_W — burst start word address.
- `host_len` in LEN_W — number of beats.
- `host_wdata` in 32 — write data for the current beat.
- `host_ack` out 1 — current beat taken; the host presents the next `host_wdata` on the following cycle.
- `host_rvalid` out 1 — read beat data valid.
- `host_rdata` out 32 — registered read data.
- `host_busy` out 1 — state ≠ IDLE.
- `host_done` out 1 — one-cycle pulse at burst end.
- `mem_addr` out ADDR_W — memory address.
- `mem_in` out 32 — memory write data.
- `mem_we` out 1 — memory write enable.
- `mem_out` in 32 — memory read data, combinational from `mem_addr`.

## Operation
- **FSM states.**
  - IDLE: `host_req` latches `host_addr`, `host_len` and `host_we`, then goes to BURST. If `host_len`==0, goes to DONE instead.
  - BURST: one beat is pending every cycle. Returns to IDLE after the last beat.
  - DONE: one cycle, pulses `host_done`, then IDLE.
- **Grant in BURST.**
  - Forced cycle: CPU denied, host granted.
  - Otherwise `cpu_req`=1: CPU granted, host denied.
  - Otherwise: host granted.
- **Grant outside BURST.** CPU always granted.
- **Memory port, CPU granted.** `mem_addr`=`cpu_addr`, `mem_we`=`cpu_we`, `mem_in`=`cpu_wdata`.
- **Memory port, host granted.** `mem_addr`=current address, `mem_we`=latched we, `mem_in`=`host_wdata`, `host_ack`=1.
- **`cpu_rdata`.** Equals `mem_out` whenever the CPU is granted; don't-care otherwise.
- **`cpu_stall`.** Equals `cpu_req` & (host granted).
- **Per host beat.** Address increments modulo 2^ADDR_W (wrap from 4095 to 0 is legal). Remaining-beat counter decrements.
- **Starvation counter.** Counts consecutive BURST cycles in which the host is denied. Clears on every host beat and on leaving BURST. When it equals STARVE_MAX, the next cycle is a forced cycle.
- **Burst end.** The last beat is the beat taken with remaining==1.
- **`host_req` while busy.** Ignored; no queuing.
- **Reset mid-burst.** Aborts the burst with no `host_done` pulse. Memory contents already written stay written.

## Timing
- **Reset values.**
  - `cpu_stall`, `host_ack`, `host_rvalid`, `host_busy`, `host_done`, `mem_we` = 0.
  - `host_rdata` = 0, state = IDLE, all counters = 0.
- **Burst start.** `host_req` at cycle t (IDLE) gives `host_busy` from t+1; the first beat is possible at t+1.
- **Reads.** A host read beat at cycle t gives `host_rvalid`=1 with `host_rdata`=`mem_out` at t+1.
- **`host_done`.**
  - Asserts in the cycle after the last beat, coinciding with the final `host_rvalid` for reads.
  - `host_busy` drops in that same cycle.
  - For `host_len`==0: `host_done` at t+1, with no memory access.
- **Uncontended burst.** N beats take N cycles and `host_done` is at t+N+1. Each CPU-granted cycle inside the burst adds one cycle.
- **Forced beat.** With `cpu_req` held high through a burst, the host gets one beat every STARVE_MAX+1 cycles. `cpu_stall` is high only on those cycles.
- **CPU latency.** Zero when granted; a stall lasts exactly one cycle.

## Configuration
- **`DMEM_ARB_STARVE_GUARD_EN` defined.** Starvation counter and forced cycles as above.
- **`DMEM_ARB_STARVE_GUARD_EN` undefined.**
  - Strict CPU priority: `cpu_stall` is constant 0 and the counter logic is absent.
  - A burst makes no progress while `cpu_req` stays high.

## Test plan
- **Read burst, idle CPU.** Preload memory words 10..13 with 0xA0..0xA3. Host read `host_addr`=10, `host_len`=4 → `host_ack` on 4 consecutive cycles; `host_rvalid` data 0xA0,0xA1,0xA2,0xA3; `host_done` 5 cycles after `host_req`.
- **Write burst with wrap.** Host write `host_addr`=4094, `host_len`=3, data 1,2,3 → words 4094, 4095, 0 hold 1, 2, 3; `host_done` once.
- **Starvation guard, macro on.** STARVE_MAX=8, `cpu_req`=1 continuously, host read `host_len`=2 → `cpu_stall` high on exactly 2 cycles, 9 cycles apart; CPU loads on all other cycles return correct data; `host_done` after the second forced beat.
- **Strict priority, macro off.** Same stimulus as the previous scenario → `cpu_stall` never asserts and `host_ack` stays 0. Drop `cpu_req` → burst completes in 2 cycles.
- **Edge cases.** `host_len`=0 → `host_done` at t+1 with `mem_we` never high. `host_req` during BURST → ignored.
- **Reset mid-burst.** `rst` during beat 2 of a 4-beat write → all outputs at reset values next cycle; no `host_done`; words 0 and 1 of the burst written, words 2 and 3 untouched.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MM stage
// (priority) and a host burst port; optional guard DMEM_ARB_STARVE_GUARD_EN.
// Ports: clk, rst (sync, active high); cpu_* MM-stage access with
// same-cycle rdata and a one-cycle stall; host_* burst request, beat ack,
// registered read data, busy and done pulse; mem_* memory port with
// combinational read data.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LEN_W-1:0]  host_len,
    input  logic [31:0]       host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic              host_busy,
    output logic              host_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_in,
    output logic              mem_we,
    input  logic [31:0]       mem_out
);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              we_q;
    logic              done_q;
    logic              in_burst;
    logic              host_gnt;
    logic              last_beat;

    assign in_burst  = (state == BURST);
    assign last_beat = host_gnt && (rem_q == LEN_W'(1));

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q;
    logic          forced;

    // Counts consecutive denied burst cycles; a full count forces the
    // next cycle to the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if (!in_burst || host_gnt) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign forced    = in_burst && (starve_q == SW'(STARVE_MAX));
    assign host_gnt  = in_burst && (forced || !cpu_req);
    assign cpu_stall = cpu_req && host_gnt;
`else
    assign host_gnt  = in_burst && !cpu_req;
    assign cpu_stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (host_req) begin
                    state_nx = (host_len == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_nx = IDLE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            rem_q       <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            done_q      <= last_beat;
            host_rvalid <= host_gnt && !we_q;
            if (host_gnt && !we_q) begin
                host_rdata <= mem_out;
            end
            if (state == IDLE && host_req) begin
                addr_q <= host_addr;
                rem_q  <= host_len;
                we_q   <= host_we;
            end else if (host_gnt) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr = cpu_addr;
        mem_in   = cpu_wdata;
        mem_we   = cpu_req && cpu_we;
        if (host_gnt) begin
            mem_addr = addr_q;
            mem_in   = host_wdata;
            mem_we   = we_q;
        end
    end

    assign cpu_rdata = mem_out;
    assign host_ack  = host_gnt;
    assign host_busy = (state != IDLE);
    // Burst completion is reported one cycle after the last beat, when the
    // FSM is already back in IDLE; the zero-length case uses DONE instead.
    assign host_done = done_q || (state == DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a behavioural
// 4096-word memory attached to the mem_* port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        host_req;
    logic        host_we;
    logic [11:0] host_addr;
    logic [7:0]  host_len;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        host_busy;
    logic        host_done;
    logic [11:0] mem_addr;
    logic [31:0] mem_in;
    logic        mem_we;
    logic [31:0] mem_out;

    logic [31:0] mem [0:4095];

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    assign mem_out = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_in;
        end
    end

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_len   (host_len),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .host_busy  (host_busy),
        .host_done  (host_done),
        .mem_addr   (mem_addr),
        .mem_in     (mem_in),
        .mem_we     (mem_we),
        .mem_out    (mem_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are
    // sampled on the falling edge of the same cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[10 + i] = 32'hA0 + i;
        for (int i = 0; i < 40; i++) mem[20 + i] = 32'h500 + i;
        for (int i = 0; i < 4; i++) mem[200 + i] = 32'h77;
        mem[100] = 32'hDEAD;

        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0;
        host_len = '0; host_wdata = '0;
        next();
        next();
        rst = 1'b0;
        sample();
        chk("rst_stall", cpu_stall, 0);
        chk("rst_ack", host_ack, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_busy", host_busy, 0);
        chk("rst_done", host_done, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rdata", host_rdata, 0);
        next();

        // Read burst of 4 from word 10 with the CPU idle.
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'd10; host_len = 8'd4;
        sample();
        chk("rd_busy0", host_busy, 0);
        next();
        host_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            sample();
            chk("rd_ack", host_ack, (c >= 1 && c <= 4));
            chk("rd_busy", host_busy, (c <= 4));
            chk("rd_done", host_done, (c == 5));
            chk("rd_rvalid", host_rvalid, (c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) chk("rd_data", host_rdata, 32'hA0 + c - 2);
            next();
        end

        // Write burst wrapping 4094 -> 0; a second request mid-burst is ignored.
        n_done = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'd4094; host_len = 8'd3;
        sample();
        next();
        host_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            host_wdata = 32'(c);
            if (c == 2) begin
                host_req = 1'b1; host_addr = 12'd100; host_len = 8'd5;
            end else begin
                host_req = 1'b0;
            end
            sample();
            if (host_done) n_done++;
            chk("wr_ack", host_ack, (c <= 3));
            chk("wr_busy", host_busy, (c <= 3));
            next();
        end
        chk("wr_done_cnt", n_done, 1);
        chk("wr_4094", mem[4094], 1);
        chk("wr_4095", mem[4095], 2);
        chk("wr_0", mem[0], 3);
        chk("wr_ignored", mem[100], 32'hDEAD);

        // Zero-length burst.
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'd300; host_len = 8'd0;
        sample();
        chk("z_mem_we0", mem_we, 0);
        next();
        host_req = 1'b0;
        sample();
        chk("z_done1", host_done, 1);
        chk("z_mem_we1", mem_we, 0);
        chk("z_ack1", host_ack, 0);
        next();
        sample();
        chk("z_done2", host_done, 0);
        chk("z_busy2", host_busy, 0);
        chk("z_mem_we2", mem_we, 0);
        next();

        // CPU write outside a burst.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd301; cpu_wdata = 32'h1234;
        sample();
        chk("cw_mem_we", mem_we, 1);
        chk("cw_stall", cpu_stall, 0);
        next();
        cpu_req = 1'b0; cpu_we = 1'b0;
        sample();
        chk("cw_word", mem[301], 32'h1234);
        next();

        // Host read of 2 beats against a CPU that loads every cycle.
        n_done = 0;
        cpu_req = 1'b1; cpu_addr = 12'd20;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'd10; host_len = 8'd2;
        sample();
        chk("sv_rdata0", cpu_rdata, 32'h500);
        next();
        host_req = 1'b0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int c = 1; c <= 21; c++) begin
            cpu_addr = 12'(20 + c);
            sample();
            chk("sv_stall", cpu_stall, (c == 9 || c == 18));
            chk("sv_ack", host_ack, (c == 9 || c == 18));
            if (!(c == 9 || c == 18)) chk("sv_cpu_data", cpu_rdata, 32'h500 + c);
            if (c == 10) chk("sv_rd0", host_rdata, 32'hA0);
            if (c == 19) chk("sv_rd1", host_rdata, 32'hA1);
            chk("sv_done", host_done, (c == 19));
            next();
        end
        cpu_req = 1'b0;
`else
        for (int c = 1; c <= 16; c++) begin
            cpu_req  = (c <= 12);
            cpu_addr = 12'(20 + c);
            sample();
            chk("sp_stall", cpu_stall, 0);
            chk("sp_ack", host_ack, (c == 13 || c == 14));
            if (c <= 12) chk("sp_cpu_data", cpu_rdata, 32'h500 + c);
            chk("sp_busy", host_busy, (c <= 14));
            chk("sp_done", host_done, (c == 15));
            if (c == 14) chk("sp_rd0", host_rdata, 32'hA0);
            if (c == 15) chk("sp_rd1", host_rdata, 32'hA1);
            next();
        end
`endif

        // Reset during the second beat of a 4-beat write at word 200.
        n_done = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'd200; host_len = 8'd4;
        sample();
        next();
        host_req = 1'b0;
        host_wdata = 32'h11;
        sample();
        chk("rm_ack1", host_ack, 1);
        next();
        host_wdata = 32'h22;
        rst = 1'b1;
        sample();
        chk("rm_ack2", host_ack, 1);
        next();
        rst = 1'b0;
        host_wdata = 32'h33;
        sample();
        chk("rm_busy", host_busy, 0);
        chk("rm_ack", host_ack, 0);
        chk("rm_done", host_done, 0);
        chk("rm_rvalid", host_rvalid, 0);
        chk("rm_rdata", host_rdata, 0);
        chk("rm_mem_we", mem_we, 0);
        chk("rm_stall", cpu_stall, 0);
        next();
        for (int c = 0; c < 3; c++) begin
            sample();
            if (host_done) n_done++;
            next();
        end
        chk("rm_no_done", n_done, 0);
        chk("rm_w0", mem[200], 32'h11);
        chk("rm_w1", mem[201], 32'h22);
        chk("rm_w2", mem[202], 32'h77);
        chk("rm_w3", mem[203], 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
